handle_remote_move: RTL and testbench

//  Receiver for MOVE messages from the opposing board. Decodes TAKE/DOWN/CURSOR messages and replays them on the local table.

---
 rtl/handle_remote_move.sv | 204 ++++++++++++++++++++
 tb/tb_handle_remote_move.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handle_remote_move.sv
// Replays opponent TAKE/DOWN/CURSOR messages onto the local table; TAKE done at 2*len+1, DOWN at n+1, reject at 1 cycle after accept.
// rx_ready is high only in IDLE; rx_en while busy is dropped and flagged on rx_overrun. Optional REMOTE_CURSOR_EN enables cursor messages.
module handle_remote_move #(
   parameter logic       PLAYER         = 1'b0,
   parameter logic [3:0] REMOTE_TURN_ST = 4'd3,
   parameter int         TABLE_COLS     = 18,
   parameter logic [3:0] MSG_TAKE       = 4'd4,
   parameter logic [3:0] MSG_DOWN       = 4'd5,
   parameter logic [3:0] MSG_CURSOR     = 4'd6,
   parameter logic [5:0] CARD_EMPTY     = 6'd54
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       interboard_rst,
   input  logic [3:0] cur_game_state,
   input  logic       rx_en,
   input  logic [3:0] rx_msg_type,
   input  logic [4:0] rx_block_x,
   input  logic [2:0] rx_block_y,
   input  logic [5:0] rx_card,
   input  logic [2:0] rx_sel_len,
   output logic       rx_ready,
   output logic [4:0] tbl_rd_x,
   output logic [2:0] tbl_rd_y,
   input  logic [5:0] tbl_rd_card,
   output logic       tbl_wr_en,
   output logic [4:0] tbl_wr_x,
   output logic [2:0] tbl_wr_y,
   output logic [5:0] tbl_wr_card,
   output logic [2:0] hold_cnt,
   output logic       move_rx_done,
   output logic       move_rx_err,
   output logic       rx_overrun,
   output logic [4:0] remote_cur_x,
   output logic [2:0] remote_cur_y
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_TAKE_RD = 3'd1;
   localparam logic [2:0] S_TAKE_WR = 3'd2;
   localparam logic [2:0] S_DOWN_WR = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;
   localparam logic [2:0] S_ERR     = 3'd5;
   localparam logic [5:0] COLS6     = 6'(TABLE_COLS);

   logic [2:0] state_q, state_d;
   logic [4:0] x_q, x_d;
   logic [2:0] y_q, y_d;
   logic [5:0] card_q, card_d;
   logic [2:0] len_q, len_d;
   logic [2:0] idx_q, idx_d;
   logic       single_q, single_d;
   logic [2:0] hold_cnt_q, hold_cnt_d;
   logic [5:0] hold_q [7];
   logic       hold_we;
   logic       ovr_q, ovr_d;
   logic       rst_all;
   logic [2:0] eff_len;
   logic [5:0] end_col;
   logic       range_bad, state_bad;
   logic [4:0] addr_x;
   logic       unused_ok;

`ifdef REMOTE_CURSOR_EN
   logic [4:0] cur_x_q, cur_x_d;
   logic [2:0] cur_y_q, cur_y_d;
`endif

   assign rst_all   = !rst || interboard_rst;
   assign addr_x    = x_q + {2'b00, idx_q};
   assign unused_ok = ^{PLAYER, MSG_CURSOR};

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      card_d     = card_q;
      len_d      = len_q;
      idx_d      = idx_q;
      single_d   = single_q;
      hold_cnt_d = hold_cnt_q;
      hold_we    = 1'b0;
      ovr_d      = rx_en && (state_q != S_IDLE);
`ifdef REMOTE_CURSOR_EN
      cur_x_d    = cur_x_q;
      cur_y_d    = cur_y_q;
`endif
      // A DOWN that empties the hold buffer spans hold_cnt cells, not rx_sel_len
      eff_len    = (rx_msg_type == MSG_DOWN && hold_cnt_q != 3'd0) ? hold_cnt_q : rx_sel_len;
      end_col    = {1'b0, rx_block_x} + {3'b000, eff_len};
      range_bad  = end_col > COLS6;
      state_bad  = cur_game_state != REMOTE_TURN_ST;
      case (state_q)
         S_IDLE: begin
            if (rx_en) begin
               x_d      = rx_block_x;
               y_d      = rx_block_y;
               card_d   = rx_card;
               len_d    = rx_sel_len;
               idx_d    = 3'd0;
               single_d = 1'b0;
               state_d  = S_ERR;
               if (rx_msg_type == MSG_TAKE) begin
                  if (!state_bad && !range_bad && hold_cnt_q == 3'd0 && rx_sel_len != 3'd0)
                     state_d = S_TAKE_RD;
               end else if (rx_msg_type == MSG_DOWN) begin
                  if (!state_bad && !range_bad) begin
                     if (hold_cnt_q != 3'd0) begin
                        state_d = S_DOWN_WR;
                        len_d   = hold_cnt_q;
                     end else if (rx_sel_len == 3'd1) begin
                        state_d  = S_DOWN_WR;
                        single_d = 1'b1;
                     end
                  end
               end
`ifdef REMOTE_CURSOR_EN
               else if (rx_msg_type == MSG_CURSOR) begin
                  cur_x_d = rx_block_x;
                  cur_y_d = rx_block_y;
                  state_d = S_DONE;
               end
`endif
            end
         end
         S_TAKE_RD: state_d = S_TAKE_WR;
         S_TAKE_WR: begin
            hold_we = 1'b1;
            if (idx_q == len_q - 3'd1) begin
               hold_cnt_d = len_q;
               state_d    = S_DONE;
            end else begin
               idx_d   = idx_q + 3'd1;
               state_d = S_TAKE_RD;
            end
         end
         S_DOWN_WR: begin
            if (idx_q == len_q - 3'd1) begin
               hold_cnt_d = 3'd0;
               state_d    = S_DONE;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_all) begin
         state_q    <= S_IDLE;
         x_q        <= '0;
         y_q        <= '0;
         card_q     <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         single_q   <= 1'b0;
         hold_cnt_q <= '0;
         ovr_q      <= 1'b0;
         for (int i = 0; i < 7; i++) hold_q[i] <= '0;
`ifdef REMOTE_CURSOR_EN
         cur_x_q    <= '0;
         cur_y_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         card_q     <= card_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         single_q   <= single_d;
         hold_cnt_q <= hold_cnt_d;
         ovr_q      <= ovr_d;
         if (hold_we) hold_q[idx_q] <= tbl_rd_card;
`ifdef REMOTE_CURSOR_EN
         cur_x_q    <= cur_x_d;
         cur_y_q    <= cur_y_d;
`endif
      end
   end

   assign rx_ready     = state_q == S_IDLE;
   assign tbl_rd_x     = addr_x;
   assign tbl_rd_y     = y_q;
   assign tbl_wr_x     = addr_x;
   assign tbl_wr_y     = y_q;
   assign tbl_wr_en    = (state_q == S_TAKE_WR) || (state_q == S_DOWN_WR);
   assign tbl_wr_card  = (state_q == S_TAKE_WR) ? CARD_EMPTY :
                         (state_q == S_DOWN_WR) ? (single_q ? card_q : hold_q[idx_q]) : 6'd0;
   assign hold_cnt     = hold_cnt_q;
   assign move_rx_done = state_q == S_DONE;
   assign move_rx_err  = state_q == S_ERR;
   assign rx_overrun   = ovr_q;

`ifdef REMOTE_CURSOR_EN
   assign remote_cur_x = cur_x_q;
   assign remote_cur_y = cur_y_q;
`else
   assign remote_cur_x = 5'd0;
   assign remote_cur_y = 3'd0;
`endif

endmodule

// File: tb/tb_handle_remote_move.sv
// Scoreboard bench for handle_remote_move: expected writes/events queued at stimulus, checked as the DUT produces them.
module tb_handle_remote_move;

   typedef struct {
      logic [4:0] x;
      logic [2:0] y;
      logic [5:0] card;
      int         cyc;
   } wr_t;

   typedef struct {
      bit is_err;
      int cyc;
   } evt_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       interboard_rst = 1'b0;
   logic [3:0] cur_game_state = 4'd3;
   logic       rx_en = 1'b0;
   logic [3:0] rx_msg_type = 4'd0;
   logic [4:0] rx_block_x = 5'd0;
   logic [2:0] rx_block_y = 3'd0;
   logic [5:0] rx_card = 6'd0;
   logic [2:0] rx_sel_len = 3'd0;
   logic       rx_ready;
   logic [4:0] tbl_rd_x;
   logic [2:0] tbl_rd_y;
   logic [5:0] tbl_rd_card = 6'd0;
   logic       tbl_wr_en;
   logic [4:0] tbl_wr_x;
   logic [2:0] tbl_wr_y;
   logic [5:0] tbl_wr_card;
   logic [2:0] hold_cnt;
   logic       move_rx_done;
   logic       move_rx_err;
   logic       rx_overrun;
   logic [4:0] remote_cur_x;
   logic [2:0] remote_cur_y;

   logic       pre_en = 1'b0;
   logic [4:0] pre_x = 5'd0;
   logic [2:0] pre_y = 3'd0;
   logic [5:0] pre_card = 6'd0;
   logic [5:0] mem [8][32];

   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   ovr_cnt = 0;
   wr_t  exp_wr[$];
   evt_t exp_evt[$];
   wr_t  mon_w;
   evt_t mon_e;

   localparam logic [3:0] T_TAKE = 4'd4;
   localparam logic [3:0] T_DOWN = 4'd5;
   localparam logic [3:0] T_CUR  = 4'd6;
   localparam logic [5:0] EMPTY  = 6'd54;

   handle_remote_move dut (
      .clk(clk), .rst(rst), .interboard_rst(interboard_rst), .cur_game_state(cur_game_state),
      .rx_en(rx_en), .rx_msg_type(rx_msg_type), .rx_block_x(rx_block_x), .rx_block_y(rx_block_y),
      .rx_card(rx_card), .rx_sel_len(rx_sel_len), .rx_ready(rx_ready),
      .tbl_rd_x(tbl_rd_x), .tbl_rd_y(tbl_rd_y), .tbl_rd_card(tbl_rd_card),
      .tbl_wr_en(tbl_wr_en), .tbl_wr_x(tbl_wr_x), .tbl_wr_y(tbl_wr_y), .tbl_wr_card(tbl_wr_card),
      .hold_cnt(hold_cnt), .move_rx_done(move_rx_done), .move_rx_err(move_rx_err),
      .rx_overrun(rx_overrun), .remote_cur_x(remote_cur_x), .remote_cur_y(remote_cur_y)
   );

   always #5 clk = ~clk;

   // Table memory with one-cycle read latency
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tbl_wr_en) mem[tbl_wr_y][tbl_wr_x] <= tbl_wr_card;
      if (pre_en) mem[pre_y][pre_x] <= pre_card;
      tbl_rd_card <= mem[tbl_rd_y][tbl_rd_x];
   end

   always @(negedge clk) begin
      if (tbl_wr_en) begin
         vectors++;
         if (exp_wr.size() == 0) begin
            miscompares++;
            $display("FAIL unexp_write got x=%0d y=%0d card=%0d cyc=%0d, want none", tbl_wr_x, tbl_wr_y, tbl_wr_card, cyc);
         end else begin
            mon_w = exp_wr.pop_front();
            if ({tbl_wr_x, tbl_wr_y, tbl_wr_card} !== {mon_w.x, mon_w.y, mon_w.card} || cyc != mon_w.cyc) begin
               miscompares++;
               $display("FAIL write got x=%0d y=%0d card=%0d cyc=%0d, want x=%0d y=%0d card=%0d cyc=%0d",
                        tbl_wr_x, tbl_wr_y, tbl_wr_card, cyc, mon_w.x, mon_w.y, mon_w.card, mon_w.cyc);
            end
         end
      end
      if (move_rx_done || move_rx_err) begin
         vectors++;
         if (exp_evt.size() == 0) begin
            miscompares++;
            $display("FAIL unexp_event got done=%0b err=%0b cyc=%0d, want none", move_rx_done, move_rx_err, cyc);
         end else begin
            mon_e = exp_evt.pop_front();
            if (move_rx_err !== mon_e.is_err || move_rx_done !== !mon_e.is_err || cyc != mon_e.cyc) begin
               miscompares++;
               $display("FAIL event got done=%0b err=%0b cyc=%0d, want err=%0b cyc=%0d",
                        move_rx_done, move_rx_err, cyc, mon_e.is_err, mon_e.cyc);
            end
         end
      end
      if (rx_overrun) ovr_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation did not finish");
   end

   task automatic push_wr(input logic [4:0] x, input logic [2:0] y, input logic [5:0] c, input int dc);
      wr_t w;
      w.x = x; w.y = y; w.card = c; w.cyc = cyc + dc;
      exp_wr.push_back(w);
   endtask

   task automatic push_evt(input bit is_err, input int dc);
      evt_t e;
      e.is_err = is_err; e.cyc = cyc + dc;
      exp_evt.push_back(e);
   endtask

   task automatic preload(input logic [4:0] x, input logic [2:0] y, input logic [5:0] c);
      pre_x = x; pre_y = y; pre_card = c; pre_en = 1'b1;
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   task automatic send(input logic [3:0] t, input logic [4:0] x, input logic [2:0] y,
                       input logic [5:0] c, input logic [2:0] l);
      rx_msg_type = t; rx_block_x = x; rx_block_y = y; rx_card = c; rx_sel_len = l;
      rx_en = 1'b1;
      @(negedge clk);
      rx_en = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 60; i++) begin
         if (exp_evt.size() == 0 && exp_wr.size() == 0 && rx_ready) break;
         @(negedge clk);
      end
      vectors++;
      if (exp_evt.size() != 0 || exp_wr.size() != 0 || !rx_ready) begin
         miscompares++;
         $display("FAIL %s_timeout got pending_wr=%0d pending_evt=%0d ready=%0b, want 0 0 1",
                  name, exp_wr.size(), exp_evt.size(), rx_ready);
         exp_wr.delete();
         exp_evt.delete();
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({rx_ready, hold_cnt, tbl_wr_en, move_rx_done, move_rx_err, rx_overrun} !== {1'b1, 3'd0, 4'b0000}) begin
         miscompares++;
         $display("FAIL reset_outputs got ready=%0b hold=%0d wr=%0b done=%0b err=%0b ovr=%0b, want 1 0 0 0 0 0",
                  rx_ready, hold_cnt, tbl_wr_en, move_rx_done, move_rx_err, rx_overrun);
      end
      vectors++;
      if ({remote_cur_x, remote_cur_y, tbl_rd_x, tbl_rd_y} !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_addr got cur=(%0d,%0d) rd=(%0d,%0d), want zeros", remote_cur_x, remote_cur_y, tbl_rd_x, tbl_rd_y);
      end
      rst = 1'b1;
      @(negedge clk);
      // message coincident with interboard reset must be ignored
      interboard_rst = 1'b1;
      send(T_DOWN, 5'd0, 3'd0, 6'd33, 3'd1);
      interboard_rst = 1'b0;
      repeat (4) @(negedge clk);
      vectors++;
      if (rx_ready !== 1'b1 || hold_cnt !== 3'd0 || mem[0][0] === 6'd33) begin
         miscompares++;
         $display("FAIL ibrst_ignore got ready=%0b hold=%0d cell=%0d, want 1 0 !=33", rx_ready, hold_cnt, mem[0][0]);
      end
   endtask

   task automatic test_take();
      preload(5'd2, 3'd1, 6'd10);
      preload(5'd3, 3'd1, 6'd11);
      preload(5'd4, 3'd1, 6'd12);
      for (int i = 0; i < 3; i++) push_wr(5'(2 + i), 3'd1, EMPTY, 2 + 2 * i);
      push_evt(1'b0, 7);
      send(T_TAKE, 5'd2, 3'd1, 6'd0, 3'd3);
      wait_idle("take");
      vectors++;
      if (hold_cnt !== 3'd3) begin
         miscompares++;
         $display("FAIL take_hold got %0d, want 3", hold_cnt);
      end
   endtask

   task automatic test_down();
      for (int i = 0; i < 3; i++) push_wr(5'(5 + i), 3'd2, 6'(10 + i), 1 + i);
      push_evt(1'b0, 4);
      send(T_DOWN, 5'd5, 3'd2, 6'd0, 3'd3);
      wait_idle("down");
      vectors++;
      if (hold_cnt !== 3'd0 || mem[2][6] !== 6'd11) begin
         miscompares++;
         $display("FAIL down_state got hold=%0d cell=%0d, want 0 11", hold_cnt, mem[2][6]);
      end
      push_wr(5'd0, 3'd0, 6'd33, 1);
      push_evt(1'b0, 2);
      send(T_DOWN, 5'd0, 3'd0, 6'd33, 3'd1);
      wait_idle("down_single");
   endtask

   task automatic test_rejects();
      push_evt(1'b1, 1);
      send(T_TAKE, 5'd16, 3'd0, 6'd0, 3'd3);
      wait_idle("rej_range");
      push_evt(1'b1, 1);
      send(T_TAKE, 5'd0, 3'd0, 6'd0, 3'd0);
      wait_idle("rej_len0");
      push_evt(1'b1, 1);
      send(T_DOWN, 5'd0, 3'd0, 6'd7, 3'd2);
      wait_idle("rej_down_len");
      push_evt(1'b1, 1);
      send(4'd9, 5'd0, 3'd0, 6'd0, 3'd1);
      wait_idle("rej_type");
      cur_game_state = 4'd2;
      push_evt(1'b1, 1);
      send(T_DOWN, 5'd0, 3'd0, 6'd7, 3'd1);
      wait_idle("rej_state");
      cur_game_state = 4'd3;
      // x+len landing exactly on the column count is legal
      preload(5'd15, 3'd7, 6'd20);
      preload(5'd16, 3'd7, 6'd21);
      preload(5'd17, 3'd7, 6'd22);
      for (int i = 0; i < 3; i++) push_wr(5'(15 + i), 3'd7, EMPTY, 2 + 2 * i);
      push_evt(1'b0, 7);
      send(T_TAKE, 5'd15, 3'd7, 6'd0, 3'd3);
      wait_idle("take_edge");
      push_evt(1'b1, 1);
      send(T_TAKE, 5'd0, 3'd0, 6'd0, 3'd1);
      wait_idle("rej_hold_full");
      for (int i = 0; i < 3; i++) push_wr(5'(1 + i), 3'd5, 6'(20 + i), 1 + i);
      push_evt(1'b0, 4);
      send(T_DOWN, 5'd1, 3'd5, 6'd0, 3'd0);
      wait_idle("down_edge");
      vectors++;
      if (hold_cnt !== 3'd0) begin
         miscompares++;
         $display("FAIL down_edge_hold got %0d, want 0", hold_cnt);
      end
   endtask

   task automatic test_overrun();
      int ovr0;
      preload(5'd2, 3'd1, 6'd40);
      preload(5'd3, 3'd1, 6'd41);
      preload(5'd4, 3'd1, 6'd42);
      ovr0 = ovr_cnt;
      for (int i = 0; i < 3; i++) push_wr(5'(2 + i), 3'd1, EMPTY, 2 + 2 * i);
      push_evt(1'b0, 7);
      send(T_TAKE, 5'd2, 3'd1, 6'd0, 3'd3);
      @(negedge clk);
      send(T_DOWN, 5'd0, 3'd6, 6'd9, 3'd1);
      wait_idle("overrun_take");
      vectors++;
      if (ovr_cnt - ovr0 != 1 || hold_cnt !== 3'd3) begin
         miscompares++;
         $display("FAIL overrun got pulses=%0d hold=%0d, want 1 3", ovr_cnt - ovr0, hold_cnt);
      end
      for (int i = 0; i < 3; i++) push_wr(5'(10 + i), 3'd6, 6'(40 + i), 1 + i);
      push_evt(1'b0, 4);
      send(T_DOWN, 5'd10, 3'd6, 6'd0, 3'd3);
      wait_idle("overrun_down");
   endtask

   task automatic test_cursor();
      logic [4:0] ex;
      logic [2:0] ey;
`ifdef REMOTE_CURSOR_EN
      ex = 5'd9; ey = 3'd4;
      push_evt(1'b0, 1);
`else
      ex = 5'd0; ey = 3'd0;
      push_evt(1'b1, 1);
`endif
      send(T_CUR, 5'd9, 3'd4, 6'd0, 3'd5);
      wait_idle("cursor");
      vectors++;
      if (remote_cur_x !== ex || remote_cur_y !== ey) begin
         miscompares++;
         $display("FAIL cursor got (%0d,%0d), want (%0d,%0d)", remote_cur_x, remote_cur_y, ex, ey);
      end
   endtask

   task automatic test_reset_mid();
      preload(5'd2, 3'd3, 6'd1);
      push_wr(5'd2, 3'd3, EMPTY, 2);
      send(T_TAKE, 5'd2, 3'd3, 6'd0, 3'd3);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      vectors++;
      if (rx_ready !== 1'b1 || hold_cnt !== 3'd0 || tbl_wr_en !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid got ready=%0b hold=%0d wr=%0b, want 1 0 0", rx_ready, hold_cnt, tbl_wr_en);
      end
      repeat (10) @(negedge clk);
      vectors++;
      if (exp_wr.size() != 0 || exp_evt.size() != 0 || mem[3][3] === EMPTY) begin
         miscompares++;
         $display("FAIL reset_mid_abort got pending_wr=%0d pending_evt=%0d cell3=%0d, want 0 0 !=54",
                  exp_wr.size(), exp_evt.size(), mem[3][3]);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_take();
      test_down();
      test_rejects();
      test_overrun();
      test_cursor();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
